// File: rtl/tqvp_vga_pkg.sv
// Shared definitions for the VGA scan-out sequencer.
// Holds the default geometry parameters and the sequencer state encoding.
package tqvp_vga_pkg;

  localparam int DEF_PIXEL_COUNT = 384;
  localparam int DEF_IDX_W       = 9;
  localparam int DEF_REP_W       = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LINE = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } scan_state_e;

endpackage

// File: rtl/tqvp_vga_rep_counter.sv
// Replication counter: counts enabled clocks from 0 up to limit, then wraps.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   en         : advance the count this cycle
//   clr        : force the count to 0 (wins over en)
//   limit      : terminal value; the count returns to 0 after reaching it
//   wrap       : combinational pulse, high when en is set and count == limit
module tqvp_vga_rep_counter
  import tqvp_vga_pkg::*;
#(
  parameter int REP_W = DEF_REP_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [REP_W-1:0] limit,
  output logic             wrap
);

  logic [REP_W-1:0] cnt_q, cnt_d;

  assign wrap = en && (cnt_q == limit);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/tqvp_vga_scanout_ctrl.sv
// Scan-out sequencer for the 1-bpp VGA peripheral. Converts beam-timing
// strobes into a framebuffer pixel index with programmable horizontal and
// vertical pixel replication, and owns the double-buffer bank select.
//
// Build option: define SCANOUT_WRAP_EN to make the pixel index wrap modulo
// PIXEL_COUNT (tiled image) instead of saturating and invalidating.
//
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   frame_start           : pulse at first active line of a frame
//   line_start            : pulse at first active pixel of each line
//   active                : beam in visible area
//   cfg_hrep / cfg_vrep   : clocks per pixel - 1 / lines per pixel row - 1
//   cfg_cols / cfg_rows   : pixels per row - 1 / pixel rows - 1
//   swap_req              : request a display-bank swap at next frame start
//   swap_pending          : swap requested but not yet applied
//   display_bank          : bank currently scanned out
//   pix_index, pix_valid  : registered VRAM index and its validity
//   done_irq              : one-cycle pulse when the last pixel row completes
module tqvp_vga_scanout_ctrl
  import tqvp_vga_pkg::*;
#(
  parameter int PIXEL_COUNT = DEF_PIXEL_COUNT,
  parameter int IDX_W       = DEF_IDX_W,
  parameter int REP_W       = DEF_REP_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_start,
  input  logic             line_start,
  input  logic             active,
  input  logic [REP_W-1:0] cfg_hrep,
  input  logic [REP_W-1:0] cfg_vrep,
  input  logic [5:0]       cfg_cols,
  input  logic [5:0]       cfg_rows,
  input  logic             swap_req,
  output logic             swap_pending,
  output logic             display_bank,
  output logic [IDX_W-1:0] pix_index,
  output logic             pix_valid,
  output logic             done_irq
);

  // One extra bit so row_base can hold PIXEL_COUNT itself when saturated.
  localparam int SW = IDX_W + 1;
  localparam logic [SW-1:0] PC_W = SW'(PIXEL_COUNT);

  scan_state_e      state_q, state_d;
  logic [5:0]       col_q, col_d;
  logic [5:0]       row_q, row_d;
  logic [SW-1:0]    row_base_q, row_base_d;
  logic [IDX_W-1:0] pix_index_q, pix_index_d;
  logic             pix_valid_q, pix_valid_d;
  logic             done_irq_q, done_irq_d;
  logic             display_bank_q, display_bank_d;
  logic             swap_pending_q, swap_pending_d;

  logic          line_go, h_en, h_clr, h_wrap, v_wrap, eol;
  logic [SW-1:0] sum, rb_next, idx_w, rb_upd;
  logic          in_range;
  logic          unused_idx_hi;

  // frame_start overrides everything, so it also suppresses line activity.
  assign line_go = !frame_start && (state_q == ST_LINE);
  assign h_en    = line_go && active;
  assign h_clr   = frame_start || (state_q == ST_HOLD && line_start);
  assign eol     = line_go && (!active || (h_wrap && col_q == cfg_cols));

  tqvp_vga_rep_counter #(.REP_W(REP_W)) u_hcnt (
    .clk(clk), .rst_n(rst_n), .en(h_en), .clr(h_clr), .limit(cfg_hrep), .wrap(h_wrap)
  );

  tqvp_vga_rep_counter #(.REP_W(REP_W)) u_vcnt (
    .clk(clk), .rst_n(rst_n), .en(eol), .clr(frame_start), .limit(cfg_vrep), .wrap(v_wrap)
  );

  assign sum      = row_base_q + SW'(col_q);
  assign rb_next  = row_base_q + SW'(cfg_cols) + SW'(1);
  assign in_range = (sum < PC_W);

`ifdef SCANOUT_WRAP_EN
  // row_base < PIXEL_COUNT and col < 64, so one subtraction is enough.
  assign idx_w  = in_range ? sum : sum - PC_W;
  assign rb_upd = (rb_next >= PC_W) ? rb_next - PC_W : rb_next;
`else
  assign idx_w  = sum;
  assign rb_upd = (rb_next >= PC_W) ? PC_W : rb_next;
`endif

  assign unused_idx_hi = idx_w[IDX_W];

  always_comb begin
    state_d        = state_q;
    col_d          = col_q;
    row_d          = row_q;
    row_base_d     = row_base_q;
    pix_index_d    = pix_index_q;
    pix_valid_d    = 1'b0;
    done_irq_d     = 1'b0;
    display_bank_d = display_bank_q;
    swap_pending_d = swap_pending_q | swap_req;

    if (frame_start) begin
      state_d    = ST_HOLD;
      row_d      = '0;
      row_base_d = '0;
      if (swap_pending_q) display_bank_d = ~display_bank_q;
      // A request coincident with frame_start waits for the next frame.
      swap_pending_d = swap_req;
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (line_start) begin
            state_d = ST_LINE;
            col_d   = '0;
          end
        end
        ST_LINE: begin
          if (active) begin
`ifdef SCANOUT_WRAP_EN
            pix_index_d = idx_w[IDX_W-1:0];
            pix_valid_d = 1'b1;
`else
            // Out-of-range indices leave the last good index on the bus.
            if (in_range) pix_index_d = idx_w[IDX_W-1:0];
            pix_valid_d = in_range;
`endif
            if (h_wrap) col_d = col_q + 6'd1;
          end
        end
        default: ;
      endcase

      if (eol) begin
        state_d = ST_HOLD;
        if (v_wrap) begin
          row_base_d = rb_upd;
          row_d      = row_q + 6'd1;
          if (row_q == cfg_rows) begin
            state_d    = ST_DONE;
            done_irq_d = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      col_q          <= '0;
      row_q          <= '0;
      row_base_q     <= '0;
      pix_index_q    <= '0;
      pix_valid_q    <= 1'b0;
      done_irq_q     <= 1'b0;
      display_bank_q <= 1'b0;
      swap_pending_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      col_q          <= col_d;
      row_q          <= row_d;
      row_base_q     <= row_base_d;
      pix_index_q    <= pix_index_d;
      pix_valid_q    <= pix_valid_d;
      done_irq_q     <= done_irq_d;
      display_bank_q <= display_bank_d;
      swap_pending_q <= swap_pending_d;
    end
  end

  assign pix_index    = pix_index_q;
  assign pix_valid    = pix_valid_q;
  assign done_irq     = done_irq_q;
  assign display_bank = display_bank_q;
  assign swap_pending = swap_pending_q;

endmodule

// File: doc/tqvp_vga_scanout_ctrl.md
Name: tqvp_vga_scanout_ctrl

Overview:
- Scan-out sequencer for the 1-bpp VGA peripheral. It turns beam-timing strobes into a framebuffer pixel index, with programmable horizontal and vertical pixel replication.
- It owns the double-buffer display-bank select and swaps banks only at frame start.
- It sits between the VGA timing generator and the VRAM read mux, replacing a free-running index counter.

Parameters:
- PIXEL_COUNT, 384, framebuffer pixels per bank.
- IDX_W, 9, pixel index width; must satisfy 2^IDX_W >= PIXEL_COUNT.
- REP_W, 8, width of the replication counters.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- frame_start  in  1  one-cycle pulse at first active line of frame
- line_start  in  1  one-cycle pulse at the first active pixel of each line
- active  in  1  beam in visible area (not blank)
- cfg_hrep  in  REP_W  clocks per pixel minus 1
- cfg_vrep  in  REP_W  lines per pixel row minus 1
- cfg_cols  in  6  pixels per row minus 1
- cfg_rows  in  6  pixel rows minus 1
- swap_req  in  1  one-cycle pulse requesting a bank swap (register write)
- swap_pending  out  1  swap requested, not yet applied
- display_bank  out  1  bank currently scanned out
- pix_index  out  IDX_W  VRAM pixel index
- pix_valid  out  1  pix_index addresses a real pixel; the mux must output bg colour when low
- done_irq  out  1  one-cycle pulse when the last pixel row completes

Behaviour:
- Reset: state=IDLE. All outputs are 0; all internal counters (col, row, hcnt, vcnt, row_base) are 0.
- States:
  - IDLE
  - LINE: emitting pixels
  - HOLD: line finished, waiting for next line_start
  - DONE: all rows emitted
- frame_start, from any state: row_base=0, row=0, vcnt=0, state=HOLD.
  - If swap_pending=1: display_bank toggles and swap_pending clears in the same edge.
- line_start, in HOLD: state=LINE, col=0, hcnt=0.
  - line_start in IDLE or DONE is ignored.
- LINE with active=1, each clk:
  - pix_index <= row_base+col (registered, 1-cycle latency from active).
  - pix_valid <= 1 if row_base+col < PIXEL_COUNT, else 0.
  - If hcnt==cfg_hrep: hcnt=0 and col++. Otherwise hcnt++.
  - If col==cfg_cols and hcnt==cfg_hrep: end-of-line, state=HOLD.
- LINE with active=0: end-of-line immediately (line truncated).
- End-of-line:
  - If vcnt==cfg_vrep: vcnt=0, row_base += cfg_cols+1, row++.
    - If row==cfg_rows: state=DONE and done_irq pulses for 1 cycle.
  - Otherwise: vcnt++.
- pix_valid=0 whenever the state is not LINE or active=0 (registered, 1-cycle latency).
- row_base saturates at PIXEL_COUNT. Once saturated, every index is invalid, and the registered pix_index holds its last value.
- swap_req sets swap_pending.
  - swap_req in the same cycle as frame_start does not swap this frame; it stays pending for the next frame_start.
  - A second swap_req while pending has no extra effect.
- frame_start arriving mid-LINE aborts the line and restarts cleanly. No done_irq is produced.
- Config changes mid-frame take effect at the next comparison. Software changes them only at vblank.

Optional Feature:
- Macro: SCANOUT_WRAP_EN
- Defined: row_base+col is reduced modulo PIXEL_COUNT, row_base wraps instead of saturating, and pix_valid stays 1 throughout LINE with active=1. This gives a tiled or repeating image.
- Undefined: the saturate/invalidate behaviour above.

Decomposition:
- Package tqvp_vga_pkg holds:
  - PIXEL_COUNT, IDX_W, REP_W defaults
  - the state encoding (IDLE, LINE, HOLD, DONE)
- One sub-module, tqvp_vga_rep_counter: a REP_W counter with enable, clear, limit input, and wrap-pulse output.
  - Instantiated twice: horizontal (hcnt) and vertical (vcnt).

Test Plan:
- Reset, then 3 frames with cfg_hrep=0, cfg_vrep=0, cfg_cols=23, cfg_rows=15 (active 24 clk/line) -> pix_index 0..383 sequential, done_irq once per frame, 1 cycle after the last line ends.
- cfg_hrep=2, cfg_vrep=1, cfg_cols=3 -> each index repeated 3 clk; the line sequence 0,1,2,3 appears twice, then 4..7.
- swap_req mid-frame -> swap_pending=1 until the next frame_start, then display_bank 0->1. swap_req coincident with frame_start -> bank unchanged that frame, swaps at the following frame_start.
- cfg_cols=31, cfg_rows=15 (512 > 384) -> pix_valid drops to 0 at index 384 and stays 0 for the rest of the frame. With SCANOUT_WRAP_EN -> index 384 appears as 0 and pix_valid stays 1.
- active drops after 10 pixels of a 24-pixel line -> state HOLD, the next line restarts at col 0 of the correct row.
- rst_n low mid-LINE, and frame_start mid-LINE -> rst_n gives all outputs 0 and IDLE on the next edge; frame_start gives restart at index 0 with no done_irq.
